hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_ctrl_sat_counter.sv | 17 +
 rtl/hazard_ctrl.sv | 95 +++++++++
 tb/tb_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, state encoding and register-match helper for the pipeline hazard controller.
package hazard_pkg;

    localparam logic RUN     = 1'b0;
    localparam logic MD_BUSY = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MD_LATENCY_DEF = 32;
    localparam int PERF_W_DEF     = 16;

    // A producer register X hazards the ID instruction if it feeds rs, or rt when rt is read; r0 never matches.
    function automatic logic reg_match(input logic [4:0] x, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (x != REG_ZERO) && ((x == rs) || (uses_rt && (x == rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with increment enable and asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the 5-stage MIPS pipeline (load-use, branch operands,
// mult/div busy, instruction-memory wait) with saturating stall and flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int PERF_W     = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic              ID_UsesRt,
    input  logic              ID_Branch,
    input  logic              ID_BranchTaken,
    input  logic              ID_Jump,
    input  logic              ID_UsesHiLo,
    input  logic              EX_MemRead,
    input  logic              EX_RegWrite,
    input  logic [4:0]        EX_WriteReg,
    input  logic              EX_MDStart,
    input  logic              MEM_MemRead,
    input  logic [4:0]        MEM_WriteReg,
    input  logic              IMem_Ready,
    output logic              PC_Write,
    output logic              IFID_Enable,
    output logic              IFID_Flush,
    output logic              IDEX_Bubble,
    output logic              MD_Busy,
    output logic [PERF_W-1:0] Stall_Count,
    output logic [PERF_W-1:0] Flush_Count
);

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

    logic       state;
    logic [7:0] md_cnt;
    logic       load_use;
    logic       br_haz;
    logic       md_haz;
    logic       stall;
    logic       redirect;

    always_comb begin
        load_use = EX_MemRead && reg_match(EX_WriteReg, ID_Rs, ID_Rt, ID_UsesRt);
        br_haz   = (ID_Branch || ID_Jump) &&
                   ((EX_RegWrite && reg_match(EX_WriteReg, ID_Rs, ID_Rt, ID_UsesRt)) ||
                    (MEM_MemRead && reg_match(MEM_WriteReg, ID_Rs, ID_Rt, ID_UsesRt)));
        md_haz   = (state == MD_BUSY) && ID_UsesHiLo;
        stall    = load_use || br_haz || md_haz;
        redirect = ID_Jump || (ID_Branch && ID_BranchTaken);
    end

    // Reset input gates the outputs directly so the pipeline freezes the instant reset asserts.
    always_comb begin
        PC_Write    = reset && !stall && (redirect || IMem_Ready);
        IFID_Enable = reset && !stall;
        IFID_Flush  = reset && !stall && (redirect || !IMem_Ready);
        IDEX_Bubble = !reset || stall;
        MD_Busy     = reset && (state == MD_BUSY);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else if (state == RUN) begin
            if (EX_MDStart) begin
                state  <= MD_BUSY;
                md_cnt <= MD_LOAD;
            end
        end else if (md_cnt == '0) begin
            state <= RUN;
        end else begin
            md_cnt <= md_cnt - 1'b1;
        end

    a_no_md_restart: assert property (@(posedge clk) disable iff (!reset)
        !((state == MD_BUSY) && EX_MDStart));

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!IFID_Enable),
        .count (Stall_Count)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (IFID_Flush),
        .count (Flush_Count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with MD_LATENCY=4 and PERF_W=4.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_WriteReg = '0, MEM_WriteReg = '0;
    logic       ID_UsesRt = 0, ID_Branch = 0, ID_BranchTaken = 0, ID_Jump = 0, ID_UsesHiLo = 0;
    logic       EX_MemRead = 0, EX_RegWrite = 0, EX_MDStart = 0, MEM_MemRead = 0, IMem_Ready = 1;
    logic       PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy;
    logic [3:0] Stall_Count, Flush_Count;

    hazard_ctrl #(.MD_LATENCY(4), .PERF_W(4)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
        .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump), .ID_UsesHiLo(ID_UsesHiLo),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .EX_MDStart(EX_MDStart), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
        .IMem_Ready(IMem_Ready), .PC_Write(PC_Write), .IFID_Enable(IFID_Enable),
        .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble), .MD_Busy(MD_Busy),
        .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs, rt;
        logic       urt, br, tk, jmp, hilo, exr, exw;
        logic [4:0] exwr;
        logic       mds, memr;
        logic [4:0] memwr;
        logic       imem;
    } stim_t;

    // o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy}
    typedef struct packed {
        stim_t      s;
        logic [4:0] o;
    } vec_t;

    localparam logic [4:0] RUNO = 5'b11000, STL = 5'b00010, RDR = 5'b11100, WAIT = 5'b01100;

    logic [4:0] sb[$];
    int         checks = 0, failures = 0;
    int         m_stall = 0, m_flush = 0;

    function automatic stim_t st(logic [4:0] rs, logic [4:0] rt, logic urt, logic br, logic tk,
                                 logic jmp, logic hilo, logic exr, logic exw, logic [4:0] exwr,
                                 logic mds, logic memr, logic [4:0] memwr, logic imem);
        return '{rs, rt, urt, br, tk, jmp, hilo, exr, exw, exwr, mds, memr, memwr, imem};
    endfunction

    task automatic apply(input stim_t s);
        ID_Rs = s.rs; ID_Rt = s.rt; ID_UsesRt = s.urt; ID_Branch = s.br; ID_BranchTaken = s.tk;
        ID_Jump = s.jmp; ID_UsesHiLo = s.hilo; EX_MemRead = s.exr; EX_RegWrite = s.exw;
        EX_WriteReg = s.exwr; EX_MDStart = s.mds; MEM_MemRead = s.memr; MEM_WriteReg = s.memwr;
        IMem_Ready = s.imem;
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        apply(v.s);
        sb.push_back(v.o);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] o;
        reset = 1'b0;
        apply(st(8, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 1));
        repeat (2) @(negedge clk);
        o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
        checks++;
        if (o !== STL) begin failures++; $display("FAIL reset_outs got=%b exp=%b", o, STL); end
        checks++;
        if (Stall_Count !== 4'd0 || Flush_Count !== 4'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", Stall_Count, Flush_Count);
        end
        @(posedge clk);
        #1;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        reset = 1'b1;
        m_stall = 0; m_flush = 0;
    endtask

    task automatic test_load_use();
        vec_t v[$];
        logic [4:0] o, e;
        v.push_back('{st(8, 0, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 1), STL});
        v.push_back('{st(8, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1), RUNO});
        v.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1), RUNO});
        v.push_back('{st(3, 8, 1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 1), STL});
        v.push_back('{st(3, 8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 1), RUNO});
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front();
            o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
            checks++;
            if (o !== e) begin failures++; $display("FAIL load_use[%0d] got=%b exp=%b", i, o, e); end
            checks++;
            if (Stall_Count !== 4'(m_stall) || Flush_Count !== 4'(m_flush)) begin
                failures++;
                $display("FAIL load_use_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, Stall_Count, Flush_Count, m_stall, m_flush);
            end
            if (!e[3]) m_stall = (m_stall == 15) ? 15 : m_stall + 1;
            if (e[2]) m_flush = (m_flush == 15) ? 15 : m_flush + 1;
        end
    endtask

    task automatic test_branch();
        vec_t v[$];
        logic [4:0] o, e;
        v.push_back('{st(8, 0, 0, 1, 1, 0, 0, 1, 1, 8, 0, 0, 0, 1), STL});
        v.push_back('{st(8, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 8, 1), STL});
        v.push_back('{st(8, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8, 1), RDR});
        v.push_back('{st(9, 0, 0, 1, 1, 0, 0, 0, 1, 9, 0, 0, 0, 1), STL});
        v.push_back('{st(9, 0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1), RUNO});
        v.push_back('{st(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0), RDR});
        v.push_back('{st(5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 1), STL});
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front();
            o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
            checks++;
            if (o !== e) begin failures++; $display("FAIL branch[%0d] got=%b exp=%b", i, o, e); end
            checks++;
            if (Stall_Count !== 4'(m_stall) || Flush_Count !== 4'(m_flush)) begin
                failures++;
                $display("FAIL branch_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, Stall_Count, Flush_Count, m_stall, m_flush);
            end
            if (!e[3]) m_stall = (m_stall == 15) ? 15 : m_stall + 1;
            if (e[2]) m_flush = (m_flush == 15) ? 15 : m_flush + 1;
        end
    endtask

    task automatic test_muldiv();
        vec_t v[$];
        logic [4:0] o, e;
        v.push_back('{st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1), RUNO});
        repeat (4) v.push_back('{st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), 5'b00011});
        v.push_back('{st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), RUNO});
        v.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), RUNO});
        repeat (4) v.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 5'b11001});
        v.push_back('{st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), RUNO});
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front();
            o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
            checks++;
            if (o !== e) begin failures++; $display("FAIL muldiv[%0d] got=%b exp=%b", i, o, e); end
            checks++;
            if (Stall_Count !== 4'(m_stall) || Flush_Count !== 4'(m_flush)) begin
                failures++;
                $display("FAIL muldiv_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, Stall_Count, Flush_Count, m_stall, m_flush);
            end
            if (!e[3]) m_stall = (m_stall == 15) ? 15 : m_stall + 1;
            if (e[2]) m_flush = (m_flush == 15) ? 15 : m_flush + 1;
        end
    endtask

    task automatic test_imem_wait();
        vec_t v[$];
        logic [4:0] o, e;
        repeat (3) v.push_back('{st(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), WAIT});
        v.push_back('{st(4, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0), STL});
        v.push_back('{st(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), RUNO});
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front();
            o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
            checks++;
            if (o !== e) begin failures++; $display("FAIL imem[%0d] got=%b exp=%b", i, o, e); end
            checks++;
            if (Stall_Count !== 4'(m_stall) || Flush_Count !== 4'(m_flush)) begin
                failures++;
                $display("FAIL imem_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, Stall_Count, Flush_Count, m_stall, m_flush);
            end
            if (!e[3]) m_stall = (m_stall == 15) ? 15 : m_stall + 1;
            if (e[2]) m_flush = (m_flush == 15) ? 15 : m_flush + 1;
        end
    endtask

    task automatic test_saturation();
        vec_t v[$];
        logic [4:0] o, e;
        repeat (20) v.push_back('{st(8, 0, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 1), STL});
        v.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), RUNO});
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front();
            o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
            checks++;
            if (o !== e) begin failures++; $display("FAIL sat[%0d] got=%b exp=%b", i, o, e); end
            checks++;
            if (Stall_Count !== 4'(m_stall) || Flush_Count !== 4'(m_flush)) begin
                failures++;
                $display("FAIL sat_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, Stall_Count, Flush_Count, m_stall, m_flush);
            end
            if (!e[3]) m_stall = (m_stall == 15) ? 15 : m_stall + 1;
            if (e[2]) m_flush = (m_flush == 15) ? 15 : m_flush + 1;
        end
        checks++;
        if (Stall_Count !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", Stall_Count); end
    endtask

    task automatic test_async_reset();
        vec_t v[$];
        logic [4:0] o, e;
        v.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), RUNO});
        v.push_back('{st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), 5'b00011});
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front();
            o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
            checks++;
            if (o !== e) begin failures++; $display("FAIL areset_pre[%0d] got=%b exp=%b", i, o, e); end
        end
        #2;
        reset = 1'b0;
        #1;
        o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
        checks++;
        if (o !== STL) begin failures++; $display("FAIL areset_outs got=%b exp=%b", o, STL); end
        checks++;
        if (Stall_Count !== 4'd0 || Flush_Count !== 4'd0) begin
            failures++; $display("FAIL areset_counts got=%0d/%0d exp=0/0", Stall_Count, Flush_Count);
        end
        @(posedge clk);
        #1;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        reset = 1'b1;
        m_stall = 0; m_flush = 0;
        v.delete();
        v.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), RUNO});
        v.push_back('{st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), RUNO});
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front();
            o = {PC_Write, IFID_Enable, IFID_Flush, IDEX_Bubble, MD_Busy};
            checks++;
            if (o !== e) begin failures++; $display("FAIL areset_post[%0d] got=%b exp=%b", i, o, e); end
            checks++;
            if (Stall_Count !== 4'(m_stall) || Flush_Count !== 4'(m_flush)) begin
                failures++;
                $display("FAIL areset_post_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, Stall_Count, Flush_Count, m_stall, m_flush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_imem_wait();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
